// File: rtl/trail_collision_reader.sv
// trail_collision_reader
// Reads the player trail RAM back for the head's next footprint and reports
// whether the head would run into an existing trail or the arena border.
// Flow: bounds check, raster scan of the BLOCK_W x BLOCK_H footprint through
// an arbitrated read port, then drain of the return pipeline.
// Optional feature macro: COLLISION_EARLY_EXIT_EN
//   defined   - stop scanning on the first non-empty pixel, drop outstanding
//               returns, hit_count saturates at 1
//   undefined - always scan the whole footprint, hit_count is exact
module trail_collision_reader #(
    parameter int          SCREEN_W    = 640,
    parameter int          BLOCK_W     = 8,
    parameter int          BLOCK_H     = 8,
    parameter int          ARENA_X_MIN = 16,
    parameter int          ARENA_X_MAX = 623,
    parameter int          ARENA_Y_MIN = 16,
    parameter int          ARENA_Y_MAX = 463,
    parameter logic [7:0]  EMPTY_VALUE = 8'h00,
    parameter int          RD_LATENCY  = 1,
    localparam int         DXW         = $clog2(BLOCK_W),
    localparam int         DYW         = $clog2(BLOCK_H),
    localparam int         CNTW        = $clog2(BLOCK_W*BLOCK_H) + 1
) (
    input  logic            VGA_CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      head_x,
    input  logic [9:0]      head_y,
    output logic            busy,
    output logic            done,
    output logic            collision,
    output logic            out_of_bounds,
    output logic [DXW-1:0]  hit_dx,
    output logic [DYW-1:0]  hit_dy,
    output logic [CNTW-1:0] hit_count,
    output logic            rd_en,
    input  logic            rd_gnt,
    output logic [18:0]     rd_addr,
    input  logic [7:0]      rd_data
);

    typedef enum logic [2:0] {S_IDLE, S_BOUNDS, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [9:0]        r_hx, r_hy;
    logic [DXW-1:0]    r_dx;
    logic [DYW-1:0]    r_dy;
    logic [18:0]       r_addr;
    logic              r_busy, r_done, r_collision, r_oob, r_rd_en;
    logic [DXW-1:0]    r_hit_dx;
    logic [DYW-1:0]    r_hit_dy;
    logic [CNTW-1:0]   r_hit_count;

    // Return pipeline: stage RD_LATENCY lines up with rd_data.
    logic [RD_LATENCY:1] r_vld;
    logic [DXW-1:0]      r_pdx [1:RD_LATENCY];
    logic [DYW-1:0]      r_pdy [1:RD_LATENCY];

    logic        w_issue, w_cmp_hit, w_flush, w_pend, w_oob, w_last;
    logic [18:0] w_base;

    // Issue/compare decode, bounds test, first address of the footprint.
    always_comb begin
        w_issue   = r_rd_en && rd_gnt;
        w_cmp_hit = r_vld[RD_LATENCY] && (rd_data != EMPTY_VALUE);
`ifdef COLLISION_EARLY_EXIT_EN
        w_flush   = w_cmp_hit;
`else
        w_flush   = 1'b0;
`endif
        // Reads still in flight after this cycle's compare.
        w_pend = 1'b0;
        for (int k = 1; k < RD_LATENCY; k++) w_pend = w_pend | r_vld[k];
        w_oob  = (r_hx < 10'(ARENA_X_MIN)) || (r_hx > 10'(ARENA_X_MAX)) ||
                 (r_hy < 10'(ARENA_Y_MIN)) || (r_hy > 10'(ARENA_Y_MAX));
        w_base = 19'(r_hy) * 19'(SCREEN_W) + 19'(r_hx);
        w_last = (r_dx == DXW'(BLOCK_W - 1)) && (r_dy == DYW'(BLOCK_H - 1));
    end

    // Shift {valid, dx, dy} alongside the RAM latency; a flush drops everything in flight.
    always_ff @(posedge VGA_CLK) begin
        if (reset || w_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[1] <= w_issue;
            for (int k = 2; k <= RD_LATENCY; k++) r_vld[k] <= r_vld[k-1];
        end
        r_pdx[1] <= r_dx;
        r_pdy[1] <= r_dy;
        for (int k = 2; k <= RD_LATENCY; k++) begin
            r_pdx[k] <= r_pdx[k-1];
            r_pdy[k] <= r_pdy[k-1];
        end
    end

    // Control FSM with registered outputs and result accumulation.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hx        <= '0;
            r_hy        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_oob       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_hit_dx    <= '0;
            r_hit_dy    <= '0;
            r_hit_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_cmp_hit) begin
                if (!r_collision) begin
                    r_collision <= 1'b1;
                    r_hit_dx    <= r_pdx[RD_LATENCY];
                    r_hit_dy    <= r_pdy[RD_LATENCY];
                end
`ifdef COLLISION_EARLY_EXIT_EN
                r_hit_count <= CNTW'(1);
`else
                r_hit_count <= r_hit_count + CNTW'(1);
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hx        <= head_x;
                        r_hy        <= head_y;
                        r_collision <= 1'b0;
                        r_oob       <= 1'b0;
                        r_hit_dx    <= '0;
                        r_hit_dy    <= '0;
                        r_hit_count <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_BOUNDS;
                    end
                end
                S_BOUNDS: begin
                    if (w_oob) begin
                        r_oob       <= 1'b1;
                        r_collision <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_addr  <= w_base;
                        r_dx    <= '0;
                        r_dy    <= '0;
                        r_rd_en <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_flush) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else if (w_issue) begin
                        if (w_last) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_DRAIN;
                        end else if (r_dx == DXW'(BLOCK_W - 1)) begin
                            r_dx   <= '0;
                            r_dy   <= r_dy + DYW'(1);
                            r_addr <= r_addr + 19'(SCREEN_W - BLOCK_W + 1);
                        end else begin
                            r_dx   <= r_dx + DXW'(1);
                            r_addr <= r_addr + 19'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_pend || w_flush) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign collision     = r_collision;
    assign out_of_bounds = r_oob;
    assign hit_dx        = r_hit_dx;
    assign hit_dy        = r_hit_dy;
    assign hit_count     = r_hit_count;
    assign rd_en         = r_rd_en;
    assign rd_addr       = r_addr;

endmodule
